// File: rtl/llc_dram_issuer_pkg.sv
// Shared types and sizing for the LLC-to-DRAM request issuer.
// Widths here fix the request and tracker entry layouts.
package llc_dram_issuer_pkg;

  localparam int PADDR_BITS    = 19;
  localparam int TAG_BITS      = 4;
  localparam int REQ_DEPTH     = 4;
  localparam int MAX_RD_OUT    = 8;
  localparam int RD_RETURN_LAT = 23;
  localparam int TS_BITS       = 16;

  typedef struct packed {
    logic                  we;
    logic [PADDR_BITS-2:0] addr;
    logic [63:0]           wdata;
    logic [TAG_BITS-1:0]   tag;
  } issue_req_t;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [TS_BITS-1:0]  due;
  } rd_track_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    OBSERVE
  } issuer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty/count and a look-ahead of the
// head and occupancy as they will be after this cycle's push/pop.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output T                           dout_nxt,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign dout_nxt  = mem_d[rd_d];
  assign count_nxt = cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/llc_dram_req_issuer.sv
// Feeds buffered LLC requests to the DDR4 controller one command per
// two cycles and returns read data in issue order a fixed time later.
module llc_dram_req_issuer
  import llc_dram_issuer_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  llc_req_valid_in,
  output logic                  llc_req_ready_out,
  input  logic                  llc_req_we_in,
  input  logic [PADDR_BITS-2:0] llc_req_addr_in,
  input  logic [63:0]           llc_req_wdata_in,
  input  logic [TAG_BITS-1:0]   llc_req_tag_in,
  output logic                  ctrl_valid_out,
  output logic [PADDR_BITS-1:0] ctrl_addr_out,
  output logic [63:0]           ctrl_wdata_out,
  output logic                  ctrl_wdata_oe_out,
  input  logic [63:0]           ctrl_rdata_in,
  input  logic                  ctrl_cs_N_in,
  input  logic                  ctrl_act_in,
  input  logic                  ctrl_col_in,
  output logic                  llc_resp_valid_out,
  output logic [TAG_BITS-1:0]   llc_resp_tag_out,
  output logic [63:0]           llc_resp_data_out,
  output logic                  rd_full_out
);

  localparam int RCW = $clog2(REQ_DEPTH) + 1;
  localparam int TCW = $clog2(MAX_RD_OUT) + 1;

  issuer_state_e         state_q, state_d;
  logic [TS_BITS-1:0]    ts_q, ts_d;
  logic                  cvalid_q, cvalid_d;
  logic [PADDR_BITS-1:0] caddr_q, caddr_d;
  logic [63:0]           cwdata_q, cwdata_d;
  logic                  coe_q, coe_d;

  issue_req_t     req_in, req_head, req_nxt;
  rd_track_t      trk_in, trk_head, trk_unused_nxt;
  logic           req_push, req_pop, req_full, req_empty;
  logic           trk_push, trk_pop, trk_full, trk_empty;
  logic [RCW-1:0] req_unused_count, req_count_nxt;
  logic [TCW-1:0] trk_count, trk_count_nxt;
  logic           col_seen, head_ok, nxt_ok;

  sync_fifo #(
    .DEPTH (REQ_DEPTH),
    .T     (issue_req_t)
  ) u_req_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (req_push),
    .din       (req_in),
    .pop       (req_pop),
    .dout      (req_head),
    .dout_nxt  (req_nxt),
    .full      (req_full),
    .empty     (req_empty),
    .count     (req_unused_count),
    .count_nxt (req_count_nxt)
  );

  sync_fifo #(
    .DEPTH (MAX_RD_OUT),
    .T     (rd_track_t)
  ) u_rd_track (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (trk_push),
    .din       (trk_in),
    .pop       (trk_pop),
    .dout      (trk_head),
    .dout_nxt  (trk_unused_nxt),
    .full      (trk_full),
    .empty     (trk_empty),
    .count     (trk_count),
    .count_nxt (trk_count_nxt)
  );

  always_comb begin
    req_in.we    = llc_req_we_in;
    req_in.addr  = llc_req_addr_in;
    req_in.wdata = llc_req_wdata_in;
    req_in.tag   = llc_req_tag_in;
    col_seen     = !ctrl_cs_N_in && ctrl_act_in && ctrl_col_in;
    req_push     = llc_req_valid_in && !req_full;
    req_pop      = (state_q == OBSERVE) && col_seen;
    trk_push     = req_pop && !req_head.we;
    trk_in.tag   = req_head.tag;
    trk_in.due   = ts_q + TS_BITS'(RD_RETURN_LAT);
    trk_pop      = !trk_empty && (trk_head.due == ts_q);
    head_ok      = !req_empty &&
                   (req_head.we || trk_count < TCW'(MAX_RD_OUT));
    // OBSERVE decides on the post-pop head and post-push read count
    nxt_ok       = (req_count_nxt != '0) &&
                   (req_nxt.we || trk_count_nxt < TCW'(MAX_RD_OUT));
    ts_d         = ts_q + 1'b1;
    state_d      = state_q;
    unique case (state_q)
      IDLE:    if (head_ok) state_d = PRESENT;
      PRESENT: state_d = OBSERVE;
      OBSERVE: state_d = nxt_ok ? PRESENT : IDLE;
      default: state_d = IDLE;
    endcase
    cvalid_d = state_d == PRESENT;
    caddr_d  = cvalid_d ? {req_nxt.we, req_nxt.addr} : '0;
    cwdata_d = cvalid_d ? req_nxt.wdata : '0;
    coe_d    = cvalid_d && req_nxt.we;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      cvalid_q <= 1'b0;
      caddr_q  <= '0;
      cwdata_q <= '0;
      coe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      cvalid_q <= cvalid_d;
      caddr_q  <= caddr_d;
      cwdata_q <= cwdata_d;
      coe_q    <= coe_d;
    end
  end

  assign llc_req_ready_out  = !req_full;
  assign ctrl_valid_out     = cvalid_q;
  assign ctrl_addr_out      = caddr_q;
  assign ctrl_wdata_out     = cwdata_q;
  assign ctrl_wdata_oe_out  = coe_q;
  assign llc_resp_valid_out = trk_pop;
  assign llc_resp_tag_out   = trk_pop ? trk_head.tag : '0;
  assign llc_resp_data_out  = trk_pop ? ctrl_rdata_in : '0;
  assign rd_full_out        = trk_full;

endmodule

// File: tb/tb_llc_dram_req_issuer.sv
// Bench for llc_dram_req_issuer: queue-based reference model checked
// every cycle, plus directed scenarios with hand-derived expectations.
module tb_llc_dram_req_issuer;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        req_valid, req_ready, req_we;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_tag;
  logic        ctrl_valid, ctrl_oe;
  logic [18:0] ctrl_addr;
  logic [63:0] ctrl_wdata, ctrl_rdata;
  logic        cs_n, act, col;
  logic        resp_valid, rd_full;
  logic [3:0]  resp_tag;
  logic [63:0] resp_data;

  always #5 clk = ~clk;

  llc_dram_req_issuer dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .llc_req_valid_in   (req_valid),
    .llc_req_ready_out  (req_ready),
    .llc_req_we_in      (req_we),
    .llc_req_addr_in    (req_addr),
    .llc_req_wdata_in   (req_wdata),
    .llc_req_tag_in     (req_tag),
    .ctrl_valid_out     (ctrl_valid),
    .ctrl_addr_out      (ctrl_addr),
    .ctrl_wdata_out     (ctrl_wdata),
    .ctrl_wdata_oe_out  (ctrl_oe),
    .ctrl_rdata_in      (ctrl_rdata),
    .ctrl_cs_N_in       (cs_n),
    .ctrl_act_in        (act),
    .ctrl_col_in        (col),
    .llc_resp_valid_out (resp_valid),
    .llc_resp_tag_out   (resp_tag),
    .llc_resp_data_out  (resp_data),
    .rd_full_out        (rd_full)
  );

  typedef struct {
    bit        we;
    bit [17:0] addr;
    bit [63:0] wdata;
    bit [3:0]  tag;
  } m_req_t;

  typedef struct {
    bit [3:0] tag;
    int       due;
  } m_trk_t;

  m_req_t m_rq[$];
  m_trk_t m_tq[$];
  m_req_t m_h, m_n;
  m_trk_t m_t;
  int     m_phase;
  int     m_ts;
  bit     m_en = 1'b0;
  bit     m_go, m_acc, m_col;

  int n_chk = 0;
  int n_err = 0;

  int       pres_total = 0;
  int       nr_total = 0;
  int       full_total = 0;
  bit [3:0] resp_tags[$];

  logic [155:0] a_v, e_v;

  bit ctl_rand = 1'b0;
  int ctl_miss = 0;
  bit ctl_kind = 1'b0;
  int miss_cnt = 0;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
      if (n_err >= 40) finish_run();
    end
  endtask

  // Reference model: compare this cycle, then advance one cycle.
  always @(negedge clk) begin
    if (m_en) begin
      e_v = '0;
      e_v[155] = m_rq.size() < 4;
      if (m_phase == 1) begin
        e_v[154]     = 1'b1;
        e_v[153:135] = {m_rq[0].we, m_rq[0].addr};
        e_v[134]     = m_rq[0].we;
        e_v[133:70]  = m_rq[0].wdata;
      end
      if (m_tq.size() > 0 && m_tq[0].due == m_ts) begin
        e_v[69]    = 1'b1;
        e_v[68:65] = m_tq[0].tag;
        e_v[64:1]  = ctrl_rdata;
      end
      e_v[0] = m_tq.size() == 8;
      a_v = {req_ready, ctrl_valid, ctrl_addr, ctrl_oe, ctrl_wdata,
             resp_valid, resp_tag, resp_data, rd_full};
      chk("cycle", a_v, e_v);
      if (ctrl_valid) pres_total++;
      if (!req_ready) nr_total++;
      if (rd_full) full_total++;
      if (resp_valid) resp_tags.push_back(resp_tag);
    end
    if (rst_in) begin
      m_rq.delete();
      m_tq.delete();
      m_phase = 0;
      m_ts    = 0;
      m_en    = 1'b1;
    end else if (m_en) begin
      m_go  = m_rq.size() > 0 && (m_rq[0].we || m_tq.size() < 8);
      m_acc = req_valid && m_rq.size() < 4;
      m_col = !cs_n && act && col;
      if (m_tq.size() > 0 && m_tq[0].due == m_ts) void'(m_tq.pop_front());
      if (m_phase == 2 && m_col) begin
        m_h = m_rq.pop_front();
        if (!m_h.we) begin
          m_t.tag = m_h.tag;
          m_t.due = (m_ts + 23) % 65536;
          m_tq.push_back(m_t);
        end
      end
      if (m_acc) begin
        m_n.we    = req_we;
        m_n.addr  = req_addr;
        m_n.wdata = req_wdata;
        m_n.tag   = req_tag;
        m_rq.push_back(m_n);
      end
      case (m_phase)
        0: m_phase = m_go ? 1 : 0;
        1: m_phase = 2;
        default: m_phase = (m_rq.size() > 0 &&
                            (m_rq[0].we || m_tq.size() < 8)) ? 1 : 0;
      endcase
      m_ts = (m_ts + 1) % 65536;
    end
  end

  // Controller stand-in: answers each presented request a cycle later.
  initial begin
    bit pres;
    int r;
    cs_n = 1'b1; act = 1'b0; col = 1'b0; ctrl_rdata = '0;
    forever begin
      @(negedge clk);
      pres = ctrl_valid;
      @(posedge clk);
      #1;
      ctrl_rdata = {$urandom, $urandom};
      r = $urandom;
      if (pres && ctl_rand) begin
        case (r % 4)
          0, 1: begin cs_n = 0; act = 1; col = 1; end
          2:    begin cs_n = 0; act = 1; col = 0; end
          default: begin cs_n = 1; act = 1; col = 1; end
        endcase
      end else if (pres && miss_cnt < ctl_miss) begin
        miss_cnt++;
        if (ctl_kind) begin
          cs_n = 1; act = 1; col = 1;
        end else if (miss_cnt == 1) begin
          cs_n = 0; act = 0; col = r[0];
        end else begin
          cs_n = 0; act = 1; col = 0;
        end
      end else if (pres) begin
        miss_cnt = 0;
        cs_n = 0; act = 1; col = 1;
      end else begin
        cs_n = r[0]; act = r[1]; col = r[2];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit we, input bit [17:0] addr,
                      input bit [63:0] wd, input bit [3:0] tag);
    tick();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_tag   = tag;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) return;
      tick();
    end
    chk("send_timeout", req_ready, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      #1;
      done = m_rq.size() == 0 && m_tq.size() == 0 && m_phase == 0;
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic wait_resp(output int lat, output logic [3:0] tg,
                           output logic [63:0] dat,
                           output logic [63:0] want_dat);
    lat = -1; tg = '0; dat = '0; want_dat = '1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid) begin
        lat = k; tg = resp_tag; dat = resp_data; want_dat = ctrl_rdata;
        break;
      end
    end
  endtask

  initial begin
    int          lat, base_p, base_r, base_nr, base_f;
    logic [3:0]  tg;
    logic [63:0] dat, want_dat;

    rst_in = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_full", rd_full, 0);

    // single write, column issued at once
    base_r = resp_tags.size();
    send(1'b1, 18'h12345, 64'hDEADBEEF, 4'h9);
    tick(); req_valid = 1'b0;
    @(negedge clk);
    tick(); @(negedge clk);
    chk("wr_valid", ctrl_valid, 1);
    chk("wr_addr", ctrl_addr, 19'h52345);
    chk("wr_oe", ctrl_oe, 1);
    chk("wr_data", ctrl_wdata, 64'hDEADBEEF);
    tick(); @(negedge clk);
    chk("wr_obs_valid", ctrl_valid, 0);
    chk("wr_obs_oe", ctrl_oe, 0);
    repeat (40) tick();
    chk("wr_no_resp", resp_tags.size() - base_r, 0);

    // single read: ACT, PRE, then RD
    ctl_miss = 2; ctl_kind = 1'b0;
    base_p = pres_total;
    send(1'b0, 18'h00abc, 64'h0, 4'h5);
    wait_resp(lat, tg, dat, want_dat);
    chk("rd_latency", lat, 30);
    chk("rd_tag", tg, 4'h5);
    chk("rd_data", dat, want_dat);
    chk("rd_pres", pres_total - base_p, 3);
    wait_idle();

    // five writes with a slow controller fill the FIFO
    ctl_miss = 4;
    base_nr = nr_total;
    for (int i = 0; i < 5; i++) send(1'b1, 18'(i), 64'(i), 4'(i));
    tick(); req_valid = 1'b0;
    wait_idle();
    chk("fill_ready_drop", nr_total > base_nr, 1);

    // nine reads: tracker fills, ninth waits
    ctl_miss = 0;
    base_f = full_total;
    base_r = resp_tags.size();
    for (int t = 0; t < 9; t++) send(1'b0, 18'(t * 3), 64'(t), 4'(t));
    tick(); req_valid = 1'b0;
    wait_idle();
    chk("rd9_full", full_total > base_f, 1);
    chk("rd9_count", resp_tags.size() - base_r, 9);
    for (int i = base_r; i < resp_tags.size(); i++)
      chk("rd9_tag", resp_tags[i], i - base_r);

    // blocked bank five times, then column
    ctl_miss = 5; ctl_kind = 1'b1;
    base_p = pres_total;
    base_r = resp_tags.size();
    send(1'b0, 18'h30000, 64'h0, 4'hc);
    tick(); req_valid = 1'b0;
    wait_idle();
    chk("blk_pres", pres_total - base_p, 6);
    chk("blk_resp", resp_tags.size() - base_r, 1);
    if (resp_tags.size() > base_r) chk("blk_tag", resp_tags[base_r], 4'hc);

    // reset while a read is in flight
    ctl_miss = 0; ctl_kind = 1'b0;
    base_r = resp_tags.size();
    send(1'b0, 18'h01111, 64'h0, 4'h7);
    tick(); req_valid = 1'b0;
    repeat (12) tick();
    tick(); rst_in = 1'b1;
    tick(); rst_in = 1'b0;
    @(negedge clk);
    chk("rrst_ready", req_ready, 1);
    chk("rrst_valid", ctrl_valid, 0);
    chk("rrst_resp", resp_valid, 0);
    repeat (40) tick();
    chk("rrst_no_resp", resp_tags.size() - base_r, 0);

    // random traffic across most of the timestamp range
    tick(); rst_in = 1'b1;
    tick(); rst_in = 1'b0;
    ctl_rand = 1'b1;
    for (int i = 0; i < 70000 && m_ts < 16'hFF00; i++) begin
      tick();
      req_valid = $urandom_range(0, 2) == 0;
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 18'($urandom);
      req_wdata = {$urandom, $urandom};
      req_tag   = 4'($urandom);
    end
    tick(); req_valid = 1'b0;
    ctl_rand = 1'b0;
    wait_idle();

    // read whose column command lands at ts 0xFFF0
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      #1;
      if (m_ts == 16'hFFED) break;
    end
    send(1'b0, 18'h2aaaa, 64'h0, 4'ha);
    wait_resp(lat, tg, dat, want_dat);
    chk("wrap_latency", lat, 26);
    chk("wrap_tag", tg, 4'ha);
    wait_idle();

    repeat (5) tick();
    finish_run();
  end

  initial begin
    #1500000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    finish_run();
  end

endmodule
